// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the execute/memory stages, the decode hazard check
// and the register file write port.
interface regfile_wb_arbiter_if #(
  parameter int DW = 32
);
  logic          alu_valid;
  logic [3:0]    alu_wa;
  logic [DW-1:0] alu_wd;
  logic          alu_ready;
  logic          mem_valid;
  logic [3:0]    mem_wa;
  logic [DW-1:0] mem_wd;
  logic          mem_ready;
  logic          sb_set;
  logic [3:0]    sb_wa;
  logic [3:0]    chk_ra1;
  logic [3:0]    chk_ra2;
  logic          stall;
  logic          we;
  logic [3:0]    wa;
  logic [DW-1:0] wd;
  logic          pc_we;
  logic [DW-1:0] pc_wd;
  logic [14:0]   pending;

  modport slave (
    input  alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd,
           sb_set, sb_wa, chk_ra1, chk_ra2,
    output alu_ready, mem_ready, stall, we, wa, wd, pc_we, pc_wd, pending
  );

  modport master (
    output alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd,
           sb_set, sb_wa, chk_ra1, chk_ra2,
    input  alu_ready, mem_ready, stall, we, wa, wd, pc_we, pc_wd, pending
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: ALU vs load writeback with anti-starvation,
// r15 redirect to the PC path, and a load-pending scoreboard driving decode stall.
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int DW       = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);
  localparam logic [3:0] PC_REG     = 4'd15;

  logic [3:0]    wait_cnt;
  logic          alu_grant;
  logic          mem_grant;
  logic          to_file;
  logic          to_pc;
  logic [3:0]    grant_wa;
  logic [DW-1:0] grant_wd;
  logic [14:0]   pending_q;
  logic [14:0]   pending_d;
  logic [15:0]   pending_ext;
  logic          we_q;
  logic [3:0]    wa_q;
  logic [DW-1:0] wd_q;
  logic          pc_we_q;
  logic [DW-1:0] pc_wd_q;
  logic          hazard1;
  logic          hazard2;

  // Loads win ties unless the ALU has been starved for MAX_WAIT cycles.
  always_comb begin
    alu_grant = bus.alu_valid && (!bus.mem_valid || wait_cnt == WAIT_LIMIT);
    mem_grant = bus.mem_valid && !alu_grant;
    grant_wa  = alu_grant ? bus.alu_wa : bus.mem_wa;
    grant_wd  = alu_grant ? bus.alu_wd : bus.mem_wd;
    to_file   = (alu_grant || mem_grant) && grant_wa != PC_REG;
    to_pc     = (alu_grant || mem_grant) && grant_wa == PC_REG;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!bus.alu_valid || alu_grant) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Address/data hold their last file write when a cycle carries no file write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      pc_we_q <= 1'b0;
      pc_wd_q <= '0;
    end else begin
      we_q    <= to_file;
      pc_we_q <= to_pc;
      if (to_file) begin
        wa_q <= grant_wa;
        wd_q <= grant_wd;
      end
      if (to_pc) pc_wd_q <= grant_wd;
    end
  end

  // NOTE: a default assignment first in every always_comb keeps it latch-free.
  always_comb begin
    pending_d = pending_q;
    if (mem_grant && bus.mem_wa != PC_REG) pending_d[bus.mem_wa] = 1'b0;
    // Applied after the clear so a freshly issued load keeps its bit set.
    if (bus.sb_set && bus.sb_wa != PC_REG) pending_d[bus.sb_wa] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // A write sitting in the output register has not reached the file yet.
  always_comb begin
    pending_ext = {1'b0, pending_q};
    hazard1 = bus.chk_ra1 != PC_REG &&
              (pending_ext[bus.chk_ra1] || (we_q && wa_q == bus.chk_ra1));
    hazard2 = bus.chk_ra2 != PC_REG &&
              (pending_ext[bus.chk_ra2] || (we_q && wa_q == bus.chk_ra2));
  end

  assign bus.alu_ready = alu_grant;
  assign bus.mem_ready = mem_grant;
  assign bus.stall     = hazard1 || hazard2;
  assign bus.we        = we_q;
  assign bus.wa        = wa_q;
  assign bus.wd        = wd_q;
  assign bus.pc_we     = pc_we_q;
  assign bus.pc_wd     = pc_wd_q;
  assign bus.pending   = pending_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table plus contention
// and asynchronous-reset sequences, registered outputs checked via a queue.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_ALU  = 2'd1;
  localparam logic [1:0] G_MEM  = 2'd2;

  typedef struct {
    logic        av;
    logic [3:0]  awa;
    logic [31:0] awd;
    logic        mv;
    logic [3:0]  mwa;
    logic [31:0] mwd;
    logic        ss;
    logic [3:0]  swa;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic        exp_ar;
    logic        exp_mr;
    logic        exp_stall;
    logic [1:0]  grant;
    logic [14:0] exp_pend;
  } vec_t;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        pc_we;
    logic [31:0] pc_wd;
    logic [14:0] pend;
  } out_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  out_t exp_q[$];
  vec_t vecs[20];

  logic [3:0]  mdl_wa;
  logic [31:0] mdl_wd;
  logic [31:0] mdl_pc_wd;

  regfile_wb_arbiter_if #(.DW(DW)) bus ();

  regfile_wb_arbiter #(.MAX_WAIT(4), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [3:0] awa, input logic [31:0] awd,
                              input logic mv, input logic [3:0] mwa, input logic [31:0] mwd,
                              input logic ss, input logic [3:0] swa,
                              input logic [3:0] ra1, input logic [3:0] ra2,
                              input logic ar, input logic mr, input logic st,
                              input logic [1:0] g, input logic [14:0] pend);
    vec_t v;
    v.av = av;  v.awa = awa; v.awd = awd;
    v.mv = mv;  v.mwa = mwa; v.mwd = mwd;
    v.ss = ss;  v.swa = swa; v.ra1 = ra1; v.ra2 = ra2;
    v.exp_ar = ar; v.exp_mr = mr; v.exp_stall = st;
    v.grant = g; v.exp_pend = pend;
    return v;
  endfunction

  function automatic vec_t idle(input logic [3:0] ra1, input logic [3:0] ra2,
                                input logic st, input logic [14:0] pend);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, ra1, ra2, 0, 0, st, G_NONE, pend);
  endfunction

  // Drive one cycle, check combinational outputs, then the registered result.
  task automatic apply(input vec_t v, input string tag);
    out_t e;
    out_t got;
    logic [3:0]  gwa;
    logic [31:0] gwd;
    bus.alu_valid = v.av;  bus.alu_wa = v.awa; bus.alu_wd = v.awd;
    bus.mem_valid = v.mv;  bus.mem_wa = v.mwa; bus.mem_wd = v.mwd;
    bus.sb_set    = v.ss;  bus.sb_wa  = v.swa;
    bus.chk_ra1   = v.ra1; bus.chk_ra2 = v.ra2;
    #1;
    check({tag, " alu_ready"}, 32'(bus.alu_ready), 32'(v.exp_ar));
    check({tag, " mem_ready"}, 32'(bus.mem_ready), 32'(v.exp_mr));
    check({tag, " stall"}, 32'(bus.stall), 32'(v.exp_stall));
    gwa = (v.grant == G_ALU) ? v.awa : v.mwa;
    gwd = (v.grant == G_ALU) ? v.awd : v.mwd;
    e.we = 1'b0;
    e.pc_we = 1'b0;
    if (v.grant != G_NONE) begin
      if (gwa == 4'd15) begin
        e.pc_we = 1'b1;
        mdl_pc_wd = gwd;
      end else begin
        e.we = 1'b1;
        mdl_wa = gwa;
        mdl_wd = gwd;
      end
    end
    e.wa = mdl_wa;
    e.wd = mdl_wd;
    e.pc_wd = mdl_pc_wd;
    e.pend = v.exp_pend;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard: queue empty, expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      got.we = bus.we; got.wa = bus.wa; got.wd = bus.wd;
      got.pc_we = bus.pc_we; got.pc_wd = bus.pc_wd; got.pend = bus.pending;
      check({tag, " we"}, 32'(got.we), 32'(e.we));
      check({tag, " wa"}, 32'(got.wa), 32'(e.wa));
      check({tag, " wd"}, got.wd, e.wd);
      check({tag, " pc_we"}, 32'(got.pc_we), 32'(e.pc_we));
      check({tag, " pc_wd"}, got.pc_wd, e.pc_wd);
      check({tag, " pending"}, 32'(got.pend), 32'(e.pend));
    end
  endtask

  // Pattern letters: 'M' both valid, mem wins; 'A' both valid, alu wins; 'm' mem only.
  task automatic contend(input string pat, input string tag);
    vec_t v;
    for (int i = 0; i < pat.len(); i++) begin
      v = mk(pat[i] != "m", 4'd1, 32'hAAAA0001, 1'b1, 4'd2, 32'hBBBB0002,
             0, 0, 4'd15, 4'd15, pat[i] == "A", pat[i] != "A", 1'b0,
             (pat[i] == "A") ? G_ALU : G_MEM, 15'h0);
      apply(v, $sformatf("%s[%0d]", tag, i));
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    mdl_wa = '0;
    mdl_wd = '0;
    mdl_pc_wd = '0;

    vecs[0]  = mk(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, G_ALU, 15'h0);
    vecs[1]  = idle(3, 0, 1, 15'h0);
    vecs[2]  = idle(3, 0, 0, 15'h0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 5, 0, 0, 0, 0, G_NONE, 15'h0020);
    vecs[4]  = idle(5, 0, 1, 15'h0020);
    vecs[5]  = mk(0, 0, 0, 1, 5, 32'h55, 0, 0, 5, 0, 0, 1, 1, G_MEM, 15'h0);
    vecs[6]  = idle(5, 0, 1, 15'h0);
    vecs[7]  = idle(5, 0, 0, 15'h0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, G_NONE, 15'h0080);
    vecs[9]  = mk(0, 0, 0, 1, 7, 32'h77, 1, 7, 0, 0, 0, 1, 0, G_MEM, 15'h0080);
    vecs[10] = idle(0, 7, 1, 15'h0080);
    vecs[11] = mk(1, 15, 32'h100, 0, 0, 0, 0, 0, 15, 15, 1, 0, 0, G_ALU, 15'h0080);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 15, 15, 0, 0, 0, 0, G_NONE, 15'h0080);
    vecs[13] = mk(0, 0, 0, 1, 15, 32'h200, 0, 0, 7, 15, 0, 1, 1, G_MEM, 15'h0080);
    vecs[14] = mk(0, 0, 0, 1, 7, 32'h7A, 0, 0, 15, 7, 0, 1, 1, G_MEM, 15'h0);
    vecs[15] = idle(1, 2, 0, 15'h0);
    vecs[16] = mk(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 0, 0, 0, 1, 0, G_MEM, 15'h0);
    vecs[17] = mk(1, 1, 32'hA1, 0, 0, 0, 0, 0, 2, 15, 1, 0, 1, G_ALU, 15'h0);
    vecs[18] = idle(1, 15, 1, 15'h0);
    vecs[19] = idle(1, 1, 0, 15'h0);

    rst_n = 1'b0;
    bus.alu_valid = 0; bus.alu_wa = 0; bus.alu_wd = 0;
    bus.mem_valid = 0; bus.mem_wa = 0; bus.mem_wd = 0;
    bus.sb_set = 0; bus.sb_wa = 0; bus.chk_ra1 = 0; bus.chk_ra2 = 0;
    #1;
    check("reset we", 32'(bus.we), 0);
    check("reset wa", 32'(bus.wa), 0);
    check("reset wd", bus.wd, 0);
    check("reset pc_we", 32'(bus.pc_we), 0);
    check("reset pc_wd", bus.pc_wd, 0);
    check("reset pending", 32'(bus.pending), 0);
    check("reset stall", 32'(bus.stall), 0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) apply(vecs[i], $sformatf("vec%0d", i));

    apply(idle(15, 15, 0, 15'h0), "pre_contend");
    contend("MMMMAMMMMA", "contend");
    apply(idle(15, 15, 0, 15'h0), "pre_clear");
    contend("MMMmMMMMA", "wait_clear");

    // Reset asserted between edges while an ALU grant is about to be registered.
    apply(mk(1, 15, 32'h300, 0, 0, 0, 1, 4, 15, 15, 1, 0, 0, G_ALU, 15'h0010), "pre_reset");
    bus.alu_valid = 1; bus.alu_wa = 4'd9; bus.alu_wd = 32'h99;
    bus.sb_set = 0; bus.chk_ra1 = 4'd4; bus.chk_ra2 = 4'd4;
    #1;
    check("mid alu_ready", 32'(bus.alu_ready), 1);
    check("mid stall", 32'(bus.stall), 1);
    rst_n = 1'b0;
    #1;
    check("async we", 32'(bus.we), 0);
    check("async wa", 32'(bus.wa), 0);
    check("async wd", bus.wd, 0);
    check("async pc_we", 32'(bus.pc_we), 0);
    check("async pc_wd", bus.pc_wd, 0);
    check("async pending", 32'(bus.pending), 0);
    check("async stall", 32'(bus.stall), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.alu_valid = 0;
    @(posedge clk);
    #1;
    check("post_reset we", 32'(bus.we), 0);
    check("post_reset wa", 32'(bus.wa), 0);
    check("post_reset pc_we", 32'(bus.pc_we), 0);
    check("post_reset pending", 32'(bus.pending), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 15-entry register file, shared by two writers: ALU writeback and memory-load writeback.
- Arbitrates between the two writers and registers the winning write. Writes addressed to r15 are routed to the PC path instead of the file.
- Holds a load-pending scoreboard and drives a read-hazard stall to the decode stage.
- Sits between the execute/memory stages and the register file's we/wa/wd inputs.

Parameters:
- MAX_WAIT, 4: consecutive cycles the ALU requester may be blocked before it is forced to win one grant (range 1..15).
- DW, 32: data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_wa  in  4  ALU destination register.
- alu_wd  in  DW  ALU write data.
- alu_ready  out  1  ALU request accepted this cycle (combinational).
- mem_valid  in  1  load writeback request.
- mem_wa  in  4  load destination register.
- mem_wd  in  DW  load data.
- mem_ready  out  1  load request accepted this cycle (combinational).
- sb_set  in  1  a load is issued this cycle; marks its destination pending.
- sb_wa  in  4  destination register of the issued load.
- chk_ra1  in  4  decode read address 1.
- chk_ra2  in  4  decode read address 2.
- stall  out  1  read hazard on chk_ra1 or chk_ra2 (combinational).
- we  out  1  register-file write enable (registered).
- wa  out  4  register-file write address (registered).
- wd  out  DW  register-file write data (registered).
- pc_we  out  1  write to r15 requested (registered).
- pc_wd  out  DW  data for the PC write (registered).
- pending  out  15  scoreboard bits, one per r0..r14.

Behaviour:
- Reset, asynchronous: we=0, wa=0, wd=0, pc_we=0, pc_wd=0, pending=0, wait counter=0. alu_ready and mem_ready follow the arbitration rules below from the first cycle after reset. A request that was in flight when reset asserted is lost, and a pending write in the output register is not performed.
- Handshake: a requester holds valid, wa and wd stable until its ready is high. Transfer occurs when valid&&ready at the clock edge. At most one grant per cycle.
- Arbitration:
  - Only one requester valid: it is granted.
  - Both valid: mem wins, unless wait_cnt==MAX_WAIT, in which case alu wins.
  - Neither valid: no grant; we=0 and pc_we=0 next cycle.
- Wait counter:
  - Increments, saturating at MAX_WAIT, on each cycle with alu_valid && !alu_ready.
  - Clears when the alu request is granted or when alu_valid=0.
  - Width 4 bits.
- Output register, latency 1: on a grant with wa!=15, the next cycle has we=1, wa=granted wa, wd=granted wd, pc_we=0.
- r15 writes: on a grant with wa==15, the next cycle has we=0 and pc_we=1, pc_wd=granted wd. wa and wd hold their previous values.
- Scoreboard update at each edge:
  - sb_set && sb_wa!=15 sets pending[sb_wa].
  - A granted mem write clears pending[mem_wa] (for mem_wa!=15).
  - Set and clear of the same bit in one cycle: set wins, because a new load has issued.
  - sb_set with sb_wa==15 is ignored.
  - ALU writes never touch the scoreboard.
- Stall: stall=1 if any of the following holds for ra in {chk_ra1, chk_ra2}, where ra!=15:
  - pending[ra]=1; or
  - we=1 && wa==ra, because the write has not yet reached the file.
- r15 reads never stall.
- No buffering beyond the output register; backpressure is carried entirely by ready.

Test Plan:
- Single ALU write: alu_valid=1, alu_wa=3, alu_wd=0xDEADBEEF -> alu_ready=1 same cycle; next cycle we=1, wa=3, wd=0xDEADBEEF; following cycle we=0.
- Contention with MAX_WAIT=4: both valid continuously (alu_wa=1, mem_wa=2) -> mem granted cycles 0-3; alu granted cycle 4; then mem again; wait counter observed returning to 0 after the alu grant.
- Scoreboard: sb_set with sb_wa=5, then chk_ra1=5 -> stall=1 while pending[5]=1. Mem write to r5 granted -> next cycle pending[5]=0 and stall=1 (we=1, wa=5). The cycle after, stall=0.
- Simultaneous set and clear: mem write to r7 granted in the same cycle as sb_set with sb_wa=7 -> pending[7]=1 after the edge.
- r15 write: alu_wa=15, alu_wd=0x100 -> next cycle pc_we=1, pc_wd=0x100, we=0. Separately, sb_set with sb_wa=15 -> pending unchanged and chk_ra1=15 gives stall=0.
- Asynchronous reset mid-grant: rst_n low between edges while a grant is being registered -> we, pc_we and pending drop to 0 immediately; after release, no stale write appears.
